uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//   Byte FIFO that buffers bursts from the system side and drains them into
//   the 115200-baud UART transmitter one byte at a time. Sits directly upstream
//   of the transmitter: drives its start/data inputs and obeys its busy output.
//   Lets producers write back-to-back bytes without tracking the serial line.
// PARAMETERS
//   DEPTH      16  FIFO entries; must be a power of two, >= 2
//   ADDR_W     4   log2(DEPTH); pointer width
//   BUSY_WAIT  4   max cycles to wait for tx_busy to rise after tx_start
// PORTS
//   clk        in   1         system clock, 50 MHz
//   rst_n      in   1         asynchronous active-low reset
//   wr_en      in   1         write strobe; accepted only when full==0
//   wr_data    in   8         byte to enqueue
//   full       out  1         FIFO holds DEPTH bytes
//   empty      out  1         FIFO holds 0 bytes
//   count      out  ADDR_W+1  bytes currently stored, 0..DEPTH
//   tx_start   out  1         one-cycle start pulse to the transmitter
//   tx_data    out  8         byte presented with tx_start, held until next pop
//   tx_busy    in   1         transmitter busy flag
//   ovf        out  1         sticky overflow flag (UART_FEEDER_OVF_EN only)
//   ovf_clr    in   1         clears ovf (UART_FEEDER_OVF_EN only)
// BEHAVIOUR
//   Single clock domain, clk only. Reset: asynchronous assert, synchronous
//   release handled outside this block.
//   Reset values: full=0, empty=1, count=0, tx_start=0, tx_data=8'h00, ovf=0,
//   pointers=0, FSM=S_IDLE. Reset mid-transfer discards all stored bytes and
//   any pending start; a byte already inside the transmitter is not recalled.
//   FIFO: write accepted iff wr_en && !full, stored at wr_ptr, wr_ptr++ mod DEPTH.
//   Pop happens only from the FSM, rd_ptr++ mod DEPTH. Pointers wrap silently.
//   count: +1 on write only, -1 on pop only, unchanged on both or neither.
//   full/empty derive from registered count, valid the cycle after the update.
//   A write while full is dropped even if a pop occurs the same cycle.
//   A write while empty is visible to the FSM the following cycle, so the
//   minimum wr_en -> tx_start latency is 2 clk.
//   FSM states:
//     S_IDLE:      if !empty && !tx_busy -> pop; tx_data<=mem[rd_ptr];
//                  tx_start<=1; go to S_WAIT_BUSY with timer=0.
//     S_WAIT_BUSY: tx_start<=0. If tx_busy==1 -> go to S_WAIT_DONE.
//                  If timer reaches BUSY_WAIT-1 without busy -> go to S_IDLE.
//                  The byte is treated as sent and is not retried.
//     S_WAIT_DONE: if tx_busy==0 -> go to S_IDLE.
//   tx_start is high for exactly one clk per popped byte. It is never
//   reasserted until busy has fallen or the timer has expired.
//   Busy rises 1 clk after start and falls at stop-bit end. The gap between
//   bytes is therefore 1 clk of transmitter idle plus the FSM return to S_IDLE.
//   Other states encode to S_IDLE.
// CONFIGURATION
//   UART_FEEDER_OVF_EN defined: ovf is set when wr_en && full; it stays set
//     until an ovf_clr cycle. If set and clear occur together, set wins.
//   UART_FEEDER_OVF_EN undefined: ovf is tied 0, ovf_clr is ignored, and no
//     overflow flop is built.
// TESTING
//   1 Reset, then write 8'hA5 once -> tx_start pulses 2 clk later with
//     tx_data=8'hA5; count goes 1->0; empty=1 after the pop.
//   2 Write 16 bytes 0x00..0x0F back-to-back while busy=1 -> full=1, count=16.
//     A 17th write is dropped; ovf=1 with the macro, ovf=0 without it.
//   3 Drain with a transmitter model (busy 1 clk after start, held 4340 clk)
//     -> bytes leave in order 0x00..0x0F, one tx_start per byte, no start
//     while busy=1.
//   4 Write 40 bytes in bursts across the drain -> pointers wrap twice and the
//     output order is identical to the input order.
//   5 Hold tx_busy=0 permanently after a start -> after BUSY_WAIT cycles the FSM
//     returns to S_IDLE and the next byte's tx_start follows; no deadlock.
//   6 Assert rst_n=0 for 1 clk in S_WAIT_DONE with count=5 -> count=0, empty=1,
//     and tx_start=0 immediately, with no further starts.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter through a start/busy handshake.
// Optional sticky overflow flag is built when UART_FEEDER_OVF_EN is defined.
module uart_tx_feeder #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned BUSY_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned TMR_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [7:0]         mem [DEPTH];
    logic [CNT_W-1:0]   count_nxt;
    logic               wr_acc;
    logic               pop;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign wr_acc = wr_en && !full;
    assign pop    = (state == S_IDLE) && !empty && !tx_busy;

    always_comb begin
        count_nxt = count;
        if (wr_acc && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!wr_acc && pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Storage array has no reset; contents are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == '0);
        end
    end

    // Drain FSM: one start pulse per byte, then wait for busy to rise and fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            rd_ptr   <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        rd_ptr   <= rd_ptr + ADDR_W'(1);
                        tx_start <= 1'b1;
                        timer    <= '0;
                        state    <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    // A transmitter that never raises busy still counts the byte as sent.
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (timer == TMR_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FEEDER_OVF_EN
    // Sticky overflow; a simultaneous set and clear leaves it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a behavioural transmitter model.
module tb_uart_tx_feeder;

    localparam int DEPTH     = 16;
    localparam int BUSY_WAIT = 4;
    localparam int MODE_NORMAL  = 0;
    localparam int MODE_FORCE_HI = 1;
    localparam int MODE_STUCK_LO = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model state (owned by the monitor process)
    byte unsigned exp_q[$];
    int  m_count = 0;
    int  m_ovf = 0;
    int  n_starts = 0;
    int  n_acc = 0;
    int  cyc = 0;
    int  start_times[$];

    // transmitter model controls
    int tx_mode = MODE_NORMAL;
    int hold_min = 8;
    int hold_max = 24;
    int hold_cnt = 0;

    uart_tx_feeder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #10 clk = ~clk;

    // Transmitter: busy rises the cycle after start and is held for a random length.
    always @(posedge clk) begin
        if (tx_mode == MODE_FORCE_HI) begin
            tx_busy  <= 1'b1;
            hold_cnt <= 0;
        end else if (tx_mode == MODE_STUCK_LO) begin
            tx_busy  <= 1'b0;
            hold_cnt <= 0;
        end else if (hold_cnt != 0) begin
            hold_cnt <= hold_cnt - 1;
            tx_busy  <= (hold_cnt != 1);
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            hold_cnt <= $urandom_range(hold_max, hold_min);
        end else begin
            tx_busy <= 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: inputs captured at one negedge are applied to the model at the next.
    task automatic run_monitor();
        logic s_valid = 1'b0;
        logic s_wr = 1'b0;
        logic s_busy = 1'b0;
        logic s_clr = 1'b0;
        byte unsigned s_data = 8'h00;
        logic prev_start = 1'b0;
        byte unsigned e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                exp_q.delete();
                m_count    = 0;
                m_ovf      = 0;
                prev_start = 1'b0;
            end else begin
                if (s_valid) begin
`ifdef UART_FEEDER_OVF_EN
                    if (s_wr && m_count == DEPTH) m_ovf = 1;
                    else if (s_clr) m_ovf = 0;
`endif
                    if (s_wr && m_count < DEPTH) begin
                        exp_q.push_back(s_data);
                        m_count++;
                        n_acc++;
                    end
                end
                if (tx_start) begin
                    chk("start_while_busy", int'(s_busy), 0);
                    chk("start_two_cycles", int'(prev_start), 0);
                    if (exp_q.size() == 0) begin
                        chk("start_with_nothing_queued", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data_order", int'(tx_data), int'(e));
                        m_count--;
                    end
                    n_starts++;
                    start_times.push_back(cyc);
                end
                chk("count", int'(count), m_count);
                chk("full", int'(full), int'(m_count == DEPTH));
                chk("empty", int'(empty), int'(m_count == 0));
                chk("ovf", int'(ovf), m_ovf);
                prev_start = tx_start;
            end
            s_valid = rst_n;
            s_wr    = wr_en;
            s_data  = wr_data;
            s_busy  = tx_busy;
            s_clr   = ovf_clr;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_tx_start", int'(tx_start), 0);
        chk("rst_ovf", int'(ovf), 0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(m_count == 0 && exp_q.size() == 0 && !tx_busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) chk(name, 0, 1);
    endtask

    initial begin
        int lat;
        int s0;
        int a0;
        int k;
        int iter;
        fork
            run_monitor();
        join_none

        // reset values; tx_data resets to zero
        do_reset();
        chk("rst_tx_data", int'(tx_data), 0);

        // single byte latency from write to start
        write_byte(8'hA5);
        chk("t1_count_after_write", int'(count), 1);
        lat = 1;
        while (!tx_start && lat < 10) begin
            step();
            lat++;
        end
        chk("t1_latency", lat, 2);
        chk("t1_tx_data", int'(tx_data), 8'hA5);
        chk("t1_count_after_pop", int'(count), 0);
        chk("t1_empty_after_pop", int'(empty), 1);
        wait_drain(200, "t1_drain_timeout");

        // fill while the transmitter is busy, then overflow
        do_reset();
        tx_mode = MODE_FORCE_HI;
        step();
        step();
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        chk("t2_full", int'(full), 1);
        chk("t2_count16", int'(count), DEPTH);
        write_byte(8'hEE);
        chk("t2_full_after_drop", int'(full), 1);
        chk("t2_count_after_drop", int'(count), DEPTH);
`ifdef UART_FEEDER_OVF_EN
        chk("t2_ovf_set", int'(ovf), 1);
`else
        chk("t2_ovf_tied", int'(ovf), 0);
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t2_ovf_cleared", int'(ovf), 0);

        // drain all sixteen in order
        s0 = n_starts;
        tx_mode = MODE_NORMAL;
        wait_drain(2000, "t3_drain_timeout");
        chk("t3_starts", n_starts - s0, DEPTH);

        // random bursts across the drain, pointers wrap
        s0 = n_starts;
        a0 = n_acc;
        iter = 0;
        while (n_acc - a0 < 40 && iter < 600) begin
            k = $urandom_range(8, 1);
            for (int j = 0; j < k; j++) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                step();
                iter++;
            end
            wr_en = 1'b0;
            repeat ($urandom_range(20, 0)) step();
        end
        wait_drain(3000, "t4_drain_timeout");
        chk("t4_at_least_40", int'(n_acc - a0 >= 40), 1);
        chk("t4_starts_match_writes", n_starts - s0, n_acc - a0);

        // transmitter never raises busy: timer expiry must keep bytes moving
        tx_mode = MODE_FORCE_HI;
        step();
        step();
        for (int i = 0; i < 5; i++) write_byte(8'($urandom));
        s0 = start_times.size();
        tx_mode = MODE_STUCK_LO;
        wait_drain(200, "t5_drain_timeout");
        chk("t5_starts", start_times.size() - s0, 5);
        for (int i = s0 + 1; i < start_times.size(); i++) begin
            lat = start_times[i] - start_times[i-1];
            chk("t5_start_gap_in_range",
                int'(lat >= BUSY_WAIT && lat <= BUSY_WAIT + 2), 1);
        end

        // reset while waiting for the transmitter with five bytes queued
        tx_mode  = MODE_NORMAL;
        hold_min = 100;
        hold_max = 100;
        step();
        step();
        for (int i = 0; i < 6; i++) write_byte(8'(8'h30 + i));
        lat = 0;
        while (!(m_count == 5 && tx_busy) && lat < 50) begin
            step();
            lat++;
        end
        chk("t6_reached_wait_done", int'(lat < 50), 1);
        chk("t6_count_before_reset", int'(count), 5);
        s0 = n_starts;
        do_reset();
        repeat (150) step();
        chk("t6_no_more_starts", n_starts - s0, 0);
        chk("t6_count_zero", int'(count), 0);
        chk("t6_empty", int'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
